phase_arbiter: RTL

- Synchronous, round-robin green-time arbiter for a four-approach intersection.
- Latches vehicle and pedestrian requests, then decides which approach gets green and for how long.
- Sequences every change through yellow, all-red clearance and an optional walk interval.
- Drives the lamp outputs directly, using the 2-bit lamp encoding used throughout the signal controllers.

---
 rtl/phase_arbiter_if.sv | 31 +++
 rtl/phase_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/phase_arbiter_if.sv
// Signal bundle between the intersection sequencer and its requesters/lamp drivers.
// PHASE_PREEMPT_EN adds the preempt request and target approach.
interface phase_arbiter_if;
  logic [3:0] req;
  logic       walk_button;
  logic [7:0] lights;
  logic       walk_light;
  logic [1:0] active_phase;
`ifdef PHASE_PREEMPT_EN
  logic       preempt;
  logic [1:0] preempt_phase;

  modport master (
    output req, walk_button, preempt, preempt_phase,
    input  lights, walk_light, active_phase
  );
  modport slave (
    input  req, walk_button, preempt, preempt_phase,
    output lights, walk_light, active_phase
  );
`else
  modport master (
    output req, walk_button,
    input  lights, walk_light, active_phase
  );
  modport slave (
    input  req, walk_button,
    output lights, walk_light, active_phase
  );
`endif
endinterface

// File: rtl/phase_arbiter.sv
// Round-robin green-time arbiter for a four-approach intersection with yellow,
// all-red clearance and pedestrian walk. Optional PHASE_PREEMPT_EN adds preemption.
//
//   state     | meaning
//   S_GREEN   | approach phase_q has right-of-way, others red
//   S_YELLOW  | approach phase_q shows yellow, others red
//   S_ALL_RED | clearance, every lamp red
//   S_WALK    | every lamp red, walk_light high
module phase_arbiter #(
  parameter int MIN_GREEN = 6,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 2,
  parameter int CLEAR_T   = 1,
  parameter int WALK_T    = 3
) (
  input logic            clk,
  input logic            rst,
  phase_arbiter_if.slave bus
);

  localparam int CW = 8;
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] C_LAST   = CW'(CLEAR_T - 1);
  localparam logic [CW-1:0] W_LAST   = CW'(WALK_T - 1);

  localparam logic [1:0] LAMP_GREEN  = 2'b10;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;

  typedef enum logic [1:0] {
    S_GREEN,
    S_YELLOW,
    S_ALL_RED,
    S_WALK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [1:0]    next_q, next_d;
  logic [3:0]    pend_q, pend_d;
  logic          walk_pend_q, walk_pend_d;
  logic [7:0]    lights_q, lights_d;
  logic          walk_light_q, walk_light_d;
  logic [1:0]    active_q, active_d;

  logic          other_demand;
  logic          green_exit;
  logic          enter_green;
  logic [1:0]    green_tgt;

  // First pending approach after p in rotation; p itself when nothing else waits.
  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] pend);
    logic [1:0] pick;
    logic [1:0] j;
    pick = p;
    for (int k = 3; k >= 1; k--) begin
      j = p + 2'(k);
      if (pend[j]) pick = j;
    end
    return pick;
  endfunction

  function automatic logic [7:0] lamp_map(input state_t s, input logic [1:0] p);
    logic [7:0] l;
    l = '0;
    if (s == S_GREEN)  l[{p, 1'b0} +: 2] = LAMP_GREEN;
    if (s == S_YELLOW) l[{p, 1'b0} +: 2] = LAMP_YELLOW;
    return l;
  endfunction

`ifdef PHASE_PREEMPT_EN
  logic       pre_act_q, pre_act_d;
  logic [1:0] pre_ph_q, pre_ph_d;
  logic       pre_any;
  logic [1:0] pre_tgt;

  assign pre_any = pre_act_q | bus.preempt;
  assign pre_tgt = bus.preempt ? bus.preempt_phase : pre_ph_q;
`endif

  assign other_demand = (|(pend_q & ~(4'b0001 << phase_q))) | walk_pend_q;

  always_comb begin
    green_exit = (cnt_q >= MIN_LAST) && other_demand &&
                 (!bus.req[phase_q] || (cnt_q == MAX_LAST));
`ifdef PHASE_PREEMPT_EN
    // Preemption overrides minimum green, and pins the green on the target.
    if (bus.preempt) green_exit = (bus.preempt_phase != phase_q);
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    next_d      = next_q;
    pend_d      = pend_q | bus.req;
    walk_pend_d = walk_pend_q | bus.walk_button;
    enter_green = 1'b0;
    green_tgt   = phase_q;
`ifdef PHASE_PREEMPT_EN
    pre_act_d = pre_act_q;
    pre_ph_d  = pre_ph_q;
    if (bus.preempt && !(state_q == S_GREEN && bus.preempt_phase == phase_q)) begin
      pre_act_d = 1'b1;
      pre_ph_d  = bus.preempt_phase;
    end
`endif

    // The approach being served never accumulates its own demand.
    if (state_q == S_GREEN) pend_d[phase_q] = pend_q[phase_q];

    unique case (state_q)
      S_GREEN: begin
        if (green_exit) begin
          state_d = S_YELLOW;
          cnt_d   = '0;
          next_d  = rr_pick(phase_q, pend_q);
        end else if (cnt_q != MAX_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_YELLOW: begin
        if (cnt_q == Y_LAST) begin
          state_d = S_ALL_RED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ALL_RED: begin
        if (cnt_q == C_LAST) begin
`ifdef PHASE_PREEMPT_EN
          if (pre_any) begin
            enter_green = 1'b1;
            green_tgt   = pre_tgt;
          end else
`endif
          if (walk_pend_q) begin
            state_d     = S_WALK;
            cnt_d       = '0;
            walk_pend_d = 1'b0;
          end else begin
            enter_green = 1'b1;
            green_tgt   = next_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WALK: begin
        if (cnt_q == W_LAST) begin
          enter_green = 1'b1;
          green_tgt   = rr_pick(phase_q, pend_q);
`ifdef PHASE_PREEMPT_EN
          if (pre_any) green_tgt = pre_tgt;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_GREEN;
        cnt_d   = '0;
      end
    endcase

    // A clear on green entry beats a same-edge request for that approach.
    if (enter_green) begin
      state_d           = S_GREEN;
      cnt_d             = '0;
      phase_d           = green_tgt;
      pend_d[green_tgt] = 1'b0;
`ifdef PHASE_PREEMPT_EN
      pre_act_d = 1'b0;
`endif
    end

    lights_d     = lamp_map(state_d, phase_d);
    walk_light_d = (state_d == S_WALK);
    active_d     = enter_green ? green_tgt : active_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_GREEN;
      cnt_q        <= '0;
      phase_q      <= 2'd0;
      next_q       <= 2'd0;
      pend_q       <= 4'b0000;
      walk_pend_q  <= 1'b0;
      lights_q     <= 8'b00_00_00_10;
      walk_light_q <= 1'b0;
      active_q     <= 2'd0;
`ifdef PHASE_PREEMPT_EN
      pre_act_q    <= 1'b0;
      pre_ph_q     <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      next_q       <= next_d;
      pend_q       <= pend_d;
      walk_pend_q  <= walk_pend_d;
      lights_q     <= lights_d;
      walk_light_q <= walk_light_d;
      active_q     <= active_d;
`ifdef PHASE_PREEMPT_EN
      pre_act_q    <= pre_act_d;
      pre_ph_q     <= pre_ph_d;
`endif
    end
  end

  assign bus.lights       = lights_q;
  assign bus.walk_light   = walk_light_q;
  assign bus.active_phase = active_q;

endmodule
